// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the data-phase state type
// used by the AHB slaves in this tree.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACC,
    ST_RD,
    ST_ERR1,
    ST_ERR2
  } slv_state_e;

endpackage

// File: rtl/ahb_slv_addr_chk.sv
// Address-phase legality check and little-endian byte-lane mask.
// AHB_SLV_WPROT_EN adds write protection of the low ROM_WORDS words.
module ahb_slv_addr_chk
  import ahb_pkg::*;
#(
  parameter int ADDR_BITS = 32,
  parameter int MEM_WORDS = 16384,
  parameter int ROM_WORDS = 1024
) (
  input  logic [ADDR_BITS-1:0] haddr,
  input  logic [2:0]           hsize,
  input  logic                 hwrite,
  output logic [3:0]           mask,
  output logic                 err
);

`ifdef AHB_SLV_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif

  localparam logic [ADDR_BITS-1:0] MEM_LIM = ADDR_BITS'(MEM_WORDS);
  localparam logic [ADDR_BITS-1:0] ROM_LIM = ADDR_BITS'(ROM_WORDS);

  logic [ADDR_BITS-1:0] widx;

  assign widx = {2'b00, haddr[ADDR_BITS-1:2]};

  always_comb begin
    mask = 4'b0000;
    err  = 1'b0;
    unique case (1'b1)
      hsize == HSIZE_BYTE: mask = 4'b0001 << haddr[1:0];
      hsize == HSIZE_HALF: begin
        mask = haddr[1] ? 4'b1100 : 4'b0011;
        err  = haddr[0];
      end
      hsize == HSIZE_WORD: begin
        mask = 4'b1111;
        err  = |haddr[1:0];
      end
      default: err = 1'b1;
    endcase
    if (widx >= MEM_LIM)
      err = 1'b1;
    if (WPROT && hwrite && (widx < ROM_LIM))
      err = 1'b1;
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave turning data-phase transfers into SRAM accesses.
// Define AHB_SLV_WPROT_EN to write-protect the low ROM_WORDS words.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_BITS   = 32,
  parameter int DATA_BITS   = 32,
  parameter int MEM_WORDS   = 16384,
  parameter int WAIT_STATES = 0,
  parameter int ROM_WORDS   = 1024,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 HSEL,
  input  logic [ADDR_BITS-1:0] HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [DATA_BITS-1:0] HWDATA,
  input  logic                 HREADY,
  output logic [DATA_BITS-1:0] HRDATA,
  output logic                 HREADYOUT,
  output logic [1:0]           HRESP,
  output logic                 SRAM_CS,
  output logic [3:0]           SRAM_WEB,
  output logic [AW-1:0]        SRAM_A,
  output logic [DATA_BITS-1:0] SRAM_D,
  input  logic [DATA_BITS-1:0] SRAM_Q
);

  localparam bit         HAS_WAIT = WAIT_STATES != 0;
  localparam logic [2:0] WS_LOAD  = 3'(WAIT_STATES - 1);

  slv_state_e           state, state_d;
  logic [AW-1:0]        addr_q;
  logic                 wr_q;
  logic [3:0]           mask_q;
  logic [2:0]           cnt_q;
  logic [DATA_BITS-1:0] rdata_q;
  logic [3:0]           mask_a;
  logic                 err_a;
  logic                 accept;
  logic                 done;

  ahb_slv_addr_chk #(
    .ADDR_BITS (ADDR_BITS),
    .MEM_WORDS (MEM_WORDS),
    .ROM_WORDS (ROM_WORDS)
  ) u_chk (
    .haddr  (HADDR),
    .hsize  (HSIZE),
    .hwrite (HWRITE),
    .mask   (mask_a),
    .err    (err_a)
  );

  assign accept = HSEL && HREADY &&
                  (HTRANS == HTRANS_NONSEQ ||
                   HTRANS == HTRANS_SEQ);

  // cycles in which the current data phase completes
  assign done = state == ST_IDLE ||
                state == ST_RD   ||
                state == ST_ERR2 ||
                (state == ST_ACC && wr_q);

  assign SRAM_A = addr_q;
  assign SRAM_D = HWDATA;

  always_comb begin
    state_d   = state;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = rdata_q;
    SRAM_CS   = 1'b0;
    SRAM_WEB  = 4'b0000;
    if (done) begin
      state_d = ST_IDLE;
      if (accept)
        state_d = err_a    ? ST_ERR1 :
                  HAS_WAIT ? ST_WAIT : ST_ACC;
    end else begin
      unique case (state)
        ST_WAIT: if (cnt_q == 3'd0) state_d = ST_ACC;
        ST_ACC:  state_d = ST_RD;
        ST_ERR1: state_d = ST_ERR2;
        default: state_d = state;
      endcase
    end
    unique case (state)
      ST_WAIT: HREADYOUT = 1'b0;
      ST_ACC: begin
        SRAM_CS = 1'b1;
        if (wr_q) SRAM_WEB  = mask_q;
        else      HREADYOUT = 1'b0;
      end
      ST_RD:   HRDATA = SRAM_Q;
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      ST_ERR2: HRESP = HRESP_ERROR;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      mask_q  <= 4'b0000;
      cnt_q   <= 3'd0;
      rdata_q <= '0;
    end else begin
      state <= state_d;
      if (done && accept) begin
        addr_q <= HADDR[AW+1:2];
        wr_q   <= HWRITE;
        mask_q <= mask_a;
        cnt_q  <= WS_LOAD;
      end else if (state == ST_WAIT) begin
        cnt_q <= cnt_q - 3'd1;
      end
      if (state == ST_RD)
        rdata_q <= SRAM_Q;
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed scoreboard bench for ahb_sram_slave: one zero-wait
// and one three-wait instance, each with its own SRAM model.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  localparam int AW = 14;
`ifdef AHB_SLV_WPROT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif
  localparam logic [31:0] B = WP ? 32'h2000 : 32'h0;

  typedef struct {
    string       tag;
    int          cyc;
    logic [1:0]  resp;
    bit          chkd;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic hreset, hsel, sel3, hwrite, hready;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;

  logic [31:0]   rd0, rd3, q0, q3, d0, d3;
  logic          ro0, ro3, cs0, cs3;
  logic [1:0]    rs0, rs3;
  logic [3:0]    we0, we3;
  logic [AW-1:0] a0, a3;
  logic [31:0]   mem0 [2**AW];
  logic [31:0]   mem3 [2**AW];

  logic          rdy, cs;
  logic [1:0]    resp;
  logic [31:0]   rdata;
  logic [3:0]    web;
  logic [AW-1:0] sa;

  exp_t        sb [$];
  logic [31:0] rm [int];
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_rd, last_a1;
  logic [3:0]  last_w1;

  initial forever #5 clk = ~clk;

  assign hready = ro0 & ro3;
  assign rdy    = sel3 ? ro3 : ro0;
  assign cs     = sel3 ? cs3 : cs0;
  assign resp   = sel3 ? rs3 : rs0;
  assign rdata  = sel3 ? rd3 : rd0;
  assign web    = sel3 ? we3 : we0;
  assign sa     = sel3 ? a3  : a0;

  ahb_sram_slave #(.WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel & ~sel3),
    .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
    .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0),
    .SRAM_CS(cs0), .SRAM_WEB(we0), .SRAM_A(a0),
    .SRAM_D(d0), .SRAM_Q(q0)
  );

  ahb_sram_slave #(.WAIT_STATES(3)) dut3 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel & sel3),
    .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
    .HRDATA(rd3), .HREADYOUT(ro3), .HRESP(rs3),
    .SRAM_CS(cs3), .SRAM_WEB(we3), .SRAM_A(a3),
    .SRAM_D(d3), .SRAM_Q(q3)
  );

  always @(posedge clk) begin
    if (cs0) begin
      if (we0 == 4'b0000) q0 <= mem0[a0];
      for (int b = 0; b < 4; b++)
        if (we0[b]) mem0[a0][8*b +: 8] <= d0[8*b +: 8];
    end
    if (cs3) begin
      if (we3 == 4'b0000) q3 <= mem3[a3];
      for (int b = 0; b < 4; b++)
        if (we3[b]) mem3[a3][8*b +: 8] <= d3[8*b +: 8];
    end
  end

  function automatic logic [3:0] lanes(logic [31:0] a, logic [2:0] sz);
    case (sz)
      3'd0:    return 4'b0001 << a[1:0];
      3'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d,
                                        logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic int key(bit s3, logic [31:0] a);
    return (s3 ? 32'h10000 : 32'h0) + {18'd0, a[15:2]};
  endfunction

  function automatic logic [31:0] rget(int k);
    return rm.exists(k) ? rm[k] : 32'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Walk one data phase from its first cycle to HREADYOUT=1.
  task automatic dphase(output int n, output logic [1:0] r1,
                        output logic [1:0] rl, output logic [31:0] rd,
                        output bit csx, output logic [3:0] w1,
                        output logic [31:0] a1);
    n = 0; csx = 0; r1 = 2'b00; rl = 2'b00;
    rd = 32'h0; w1 = 4'h0; a1 = 32'h0;
    forever begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        r1 = resp;
        w1 = web;
        a1 = 32'(sa);
      end
      if (cs) csx = 1;
      if (rdy) begin
        rl = resp;
        rd = rdata;
        break;
      end
      if (n >= 16) begin
        n = -1;
        break;
      end
      tick();
    end
  endtask

  task automatic xfer(input string tag, input bit s3,
                      input logic [31:0] a, input bit w,
                      input logic [2:0] sz, input logic [31:0] wd,
                      input int ecyc, input logic [1:0] eresp);
    exp_t e;
    int n;
    logic [1:0] r1, rl;
    logic [31:0] rd, a1;
    logic [3:0] w1;
    bit csx;
    e.tag  = tag;
    e.cyc  = ecyc;
    e.resp = eresp;
    e.chkd = !w && eresp == HRESP_OKAY;
    e.data = e.chkd ? rget(key(s3, a)) : 32'h0;
    sb.push_back(e);
    sel3 = s3; hsel = 1; haddr = a; hwrite = w;
    hsize = sz; htrans = HTRANS_NONSEQ;
    tick();
    hsel = 0; htrans = HTRANS_IDLE; hwdata = wd;
    dphase(n, r1, rl, rd, csx, w1, a1);
    e = sb.pop_front();
    chk({e.tag, "_cyc"}, n, e.cyc);
    chk({e.tag, "_resp"}, 32'(rl), 32'(e.resp));
    if (e.resp == HRESP_ERROR) begin
      chk({e.tag, "_resp1"}, 32'(r1), 32'(HRESP_ERROR));
      chk({e.tag, "_nocs"}, 32'(csx), 32'h0);
    end
    if (e.chkd) chk({e.tag, "_data"}, rd, e.data);
    if (w && e.resp == HRESP_OKAY)
      rm[key(s3, a)] = merge(rget(key(s3, a)), wd, lanes(a, sz));
    last_rd = rd; last_w1 = w1; last_a1 = a1;
    tick();
  endtask

  initial begin
    exp_t e;
    int n;
    logic [1:0] r1, rl;
    logic [31:0] rd, a1;
    logic [3:0] w1;
    bit csx;

    hreset = 1; hsel = 0; sel3 = 0; haddr = 32'h0;
    htrans = HTRANS_IDLE; hwrite = 0; hsize = 3'd0; hwdata = 32'h0;
    repeat (2) tick();
    hreset = 0;
    @(negedge clk);
    chk("rst_rdy0", 32'(ro0), 32'h1);
    chk("rst_rdy3", 32'(ro3), 32'h1);
    chk("rst_resp", 32'(rs0), 32'h0);
    chk("rst_rdata", rd0, 32'h0);
    chk("rst_cs", 32'(cs0), 32'h0);
    chk("rst_web", 32'(we0), 32'h0);
    tick();

    xfer("w_dead", 0, B + 32'h10, 1, HSIZE_WORD, 32'hDEADBEEF, 1, HRESP_OKAY);
    chk("w_dead_web", 32'(last_w1), 32'hF);
    chk("w_dead_addr", last_a1, (B + 32'h10) >> 2);
    xfer("r_dead", 0, B + 32'h10, 0, HSIZE_WORD, 32'h0, 2, HRESP_OKAY);
    chk("r_dead_val", last_rd, 32'hDEADBEEF);
    @(negedge clk);
    chk("rdata_hold", rd0, 32'hDEADBEEF);
    tick();

    xfer("w_byte", 0, B + 32'h13, 1, HSIZE_BYTE, 32'hABABABAB, 1, HRESP_OKAY);
    chk("w_byte_web", 32'(last_w1), 32'h8);
    xfer("r_abad", 0, B + 32'h10, 0, HSIZE_WORD, 32'h0, 2, HRESP_OKAY);
    chk("r_abad_val", last_rd, 32'hABADBEEF);

    xfer("e_half", 0, B + 32'h11, 1, HSIZE_HALF, 32'h12341234, 2, HRESP_ERROR);
    xfer("e_size", 0, B + 32'h10, 0, 3'd3, 32'h0, 2, HRESP_ERROR);
    xfer("e_word", 0, B + 32'h12, 0, HSIZE_WORD, 32'h0, 2, HRESP_ERROR);
    xfer("e_range", 0, 32'h0001_0000, 1, HSIZE_WORD, 32'h0, 2, HRESP_ERROR);
    xfer("w_half", 0, B + 32'h12, 1, HSIZE_HALF, 32'h55555555, 1, HRESP_OKAY);
    chk("w_half_web", 32'(last_w1), 32'hC);
    xfer("r_half", 0, B + 32'h10, 0, HSIZE_WORD, 32'h0, 2, HRESP_OKAY);
    chk("r_half_val", last_rd, 32'h5555BEEF);

    xfer("wp_ffc", 0, 32'h0FFC, 1, HSIZE_WORD, 32'h11111111,
         WP ? 2 : 1, WP ? HRESP_ERROR : HRESP_OKAY);
    xfer("wp_1000", 0, 32'h1000, 1, HSIZE_WORD, 32'h22222222, 1, HRESP_OKAY);
    xfer("r_1000", 0, 32'h1000, 0, HSIZE_WORD, 32'h0, 2, HRESP_OKAY);

    xfer("w3_10", 1, B + 32'h10, 1, HSIZE_WORD, 32'hCAFEF00D, 4, HRESP_OKAY);

    e.tag = "b2b_rd"; e.cyc = 5; e.resp = HRESP_OKAY;
    e.chkd = 1; e.data = rget(key(1, B + 32'h10));
    sb.push_back(e);
    e.tag = "b2b_wr"; e.cyc = 4; e.chkd = 0; e.data = 32'h0;
    sb.push_back(e);
    sel3 = 1; hsel = 1; haddr = B + 32'h10; hwrite = 0;
    hsize = HSIZE_WORD; htrans = HTRANS_NONSEQ;
    tick();
    haddr = B + 32'h14; hwrite = 1;
    dphase(n, r1, rl, rd, csx, w1, a1);
    e = sb.pop_front();
    chk({e.tag, "_cyc"}, n, e.cyc);
    chk({e.tag, "_resp"}, 32'(rl), 32'(e.resp));
    chk({e.tag, "_data"}, rd, e.data);
    tick();
    hsel = 0; htrans = HTRANS_IDLE; hwdata = 32'h0BADF00D;
    dphase(n, r1, rl, rd, csx, w1, a1);
    e = sb.pop_front();
    chk({e.tag, "_cyc"}, n, e.cyc);
    chk({e.tag, "_resp"}, 32'(rl), 32'(e.resp));
    rm[key(1, B + 32'h14)] = 32'h0BADF00D;
    tick();
    xfer("r3_14", 1, B + 32'h14, 0, HSIZE_WORD, 32'h0, 5, HRESP_OKAY);

    xfer("w3_20", 1, B + 32'h20, 1, HSIZE_WORD, 32'h11223344, 4, HRESP_OKAY);
    sel3 = 1; hsel = 1; haddr = B + 32'h20; hwrite = 1;
    hsize = HSIZE_WORD; htrans = HTRANS_NONSEQ;
    tick();
    hsel = 0; htrans = HTRANS_IDLE; hwdata = 32'h55667788;
    @(negedge clk);
    chk("mid_wait_rdy", 32'(ro3), 32'h0);
    hreset = 1;
    tick();
    hreset = 0;
    @(negedge clk);
    chk("mid_rst_rdy", 32'(ro3), 32'h1);
    chk("mid_rst_resp", 32'(rs3), 32'h0);
    chk("mid_rst_cs", 32'(cs3), 32'h0);
    tick();
    xfer("r3_20", 1, B + 32'h20, 0, HSIZE_WORD, 32'h0, 5, HRESP_OKAY);
    chk("r3_20_val", last_rd, 32'h11223344);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
